mem_arbiter: RTL and testbench

- Shares one single-port, synchronous-read data memory (`memory`) between the processor's instruction-fetch port (I) and its load/store port (D).
- Sits between `PROCESSOR` and `memory`. It arbitrates per cycle, registers the winning command, tags the outstanding read and routes returned data to the correct requester.
- Data port has fixed priority. A starvation guard and a lock mode (for read-modify-write sequences) bound and suspend fetch access.

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one synchronous-read memory between instruction fetch (I) and load/store (D).
// D has fixed priority; a starvation counter and a D-held lock mode bound and suspend fetch access.
module mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic              IGnt,
  output logic              IValid,
  output logic [DATA_W-1:0] IRData,
  input  logic              DReq,
  input  logic              DWrite,
  input  logic              DLock,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWData,
  output logic              DGnt,
  output logic              DValid,
  output logic [DATA_W-1:0] DRData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemReadEn,
  output logic              MemWriteEn,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  output logic              Busy
);

  typedef enum logic [0:0] {ARB = 1'b0, LOCKED = 1'b1} state_t;
  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_I = 2'd1, TAG_D = 2'd2} tag_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t              state_r, state_nxt_s;
  logic [3:0]          cnt_r;
  logic                starve_hit_s;
  logic                i_gnt_s, d_gnt_s;
  tag_t                tag1_r, tag2_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic                mem_re_r, mem_we_r;
  logic [DATA_W-1:0]   mem_wdata_r;

  assign starve_hit_s = (cnt_r == LIMIT);

  // Per-cycle grant decision and lock FSM next state
  always_comb begin
    i_gnt_s     = 1'b0;
    d_gnt_s     = 1'b0;
    state_nxt_s = state_r;
    if (!nReset) begin
      state_nxt_s = ARB;
    end else begin
      case (state_r)
        ARB: begin
          i_gnt_s = IReq && (!DReq || starve_hit_s);
          d_gnt_s = DReq && !i_gnt_s;
          if (d_gnt_s && DLock) begin
            state_nxt_s = LOCKED;
          end else begin
            state_nxt_s = ARB;
          end
        end
        LOCKED: begin
          // The release cycle still arbitrates as locked; fetch waits one more cycle.
          d_gnt_s = DReq;
          if (DLock) begin
            state_nxt_s = LOCKED;
          end else begin
            state_nxt_s = ARB;
          end
        end
        default: begin
          state_nxt_s = ARB;
        end
      endcase
    end
  end

  // Lock FSM state register
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_r <= ARB;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Consecutive-denial counter for fetch, saturating at the limit
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      cnt_r <= 4'd0;
    end else if (i_gnt_s || !IReq) begin
      cnt_r <= 4'd0;
    end else if (!starve_hit_s) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Command stage: winner drives memory in the following cycle; address/data hold when idle
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_re_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      mem_re_r <= i_gnt_s | (d_gnt_s & !DWrite);
      mem_we_r <= d_gnt_s & DWrite;
      if (i_gnt_s) begin
        mem_addr_r <= IAddr;
      end else if (d_gnt_s) begin
        mem_addr_r  <= DAddr;
        mem_wdata_r <= DWData;
      end else begin
        mem_addr_r  <= mem_addr_r;
        mem_wdata_r <= mem_wdata_r;
      end
    end
  end

  // Owner tag travels alongside the read command until the data returns
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      tag1_r <= TAG_NONE;
      tag2_r <= TAG_NONE;
    end else begin
      if (i_gnt_s) begin
        tag1_r <= TAG_I;
      end else if (d_gnt_s && !DWrite) begin
        tag1_r <= TAG_D;
      end else begin
        tag1_r <= TAG_NONE;
      end
      tag2_r <= tag1_r;
    end
  end

  assign IGnt       = i_gnt_s;
  assign DGnt       = d_gnt_s;
  assign IValid     = nReset && (tag2_r == TAG_I);
  assign DValid     = nReset && (tag2_r == TAG_D);
  assign IRData     = MemRData;
  assign DRData     = MemRData;
  assign MemAddr    = mem_addr_r;
  assign MemReadEn  = mem_re_r;
  assign MemWriteEn = mem_we_r;
  assign MemWData   = mem_wdata_r;
  assign Busy       = (state_r == LOCKED);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: bench-side memory, a per-cycle reference model of the arbitration rules,
// directed scenarios with literal expectations, then a randomized phase.
module tb_mem_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          nReset;
  logic          IReq, DReq, DWrite, DLock;
  logic [AW-1:0] IAddr, DAddr;
  logic [DW-1:0] DWData;
  logic          IGnt, IValid, DGnt, DValid, MemReadEn, MemWriteEn, Busy;
  logic [DW-1:0] IRData, DRData, MemWData, MemRData;
  logic [AW-1:0] MemAddr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .Clock(clk), .nReset(nReset),
    .IReq(IReq), .IAddr(IAddr), .IGnt(IGnt), .IValid(IValid), .IRData(IRData),
    .DReq(DReq), .DWrite(DWrite), .DLock(DLock), .DAddr(DAddr), .DWData(DWData),
    .DGnt(DGnt), .DValid(DValid), .DRData(DRData),
    .MemAddr(MemAddr), .MemReadEn(MemReadEn), .MemWriteEn(MemWriteEn),
    .MemWData(MemWData), .MemRData(MemRData), .Busy(Busy)
  );

  function automatic logic [31:0] init_word(int a);
    if (a == 16) return 32'hDEADBEEF;
    return {8'(a), 8'hA5, 8'(a * 3), 8'h5A};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Synchronous-read memory, 256 words
  logic [DW-1:0] mem [0:255];
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else begin
      if (MemWriteEn) mem[MemAddr[7:0]] <= MemWData;
      if (MemReadEn)  MemRData <= mem[MemAddr[7:0]];
    end
  end

  // Reference model: what memory must see this cycle and which response is due
  typedef struct {
    bit          re;
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          tag;   // 0 none, 1 fetch, 2 data
    logic [31:0] data;
  } cmd_t;

  cmd_t        cur;
  int          resp_tag;
  logic [31:0] resp_data;
  int          m_cnt;
  bit          m_locked;
  logic [31:0] ref_mem [0:255];
  bit          ref_init = 1'b0;
  bit          last_ig, last_dg;

  always @(negedge clk) begin
    bit eg_i, eg_d, ev_i, ev_d;
    if (!ref_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      cur = '{re: 1'b0, we: 1'b0, addr: 16'h0, wdata: 32'h0, tag: 0, data: 32'h0};
      resp_tag = 0; resp_data = 32'h0; m_cnt = 0; m_locked = 1'b0;
      ref_init = 1'b1;
    end
    if (!nReset) begin
      eg_i = 1'b0; eg_d = 1'b0;
    end else if (m_locked) begin
      eg_i = 1'b0; eg_d = DReq;
    end else begin
      eg_i = IReq && (!DReq || m_cnt == LIM);
      eg_d = DReq && !eg_i;
    end
    ev_i = nReset && resp_tag == 1;
    ev_d = nReset && resp_tag == 2;
    chk("IGnt", 64'(IGnt), 64'(eg_i));
    chk("DGnt", 64'(DGnt), 64'(eg_d));
    chk("Busy", 64'(Busy), 64'(m_locked));
    chk("MemReadEn", 64'(MemReadEn), 64'(cur.re));
    chk("MemWriteEn", 64'(MemWriteEn), 64'(cur.we));
    chk("MemAddr", 64'(MemAddr), 64'(cur.addr));
    chk("MemWData", 64'(MemWData), 64'(cur.wdata));
    chk("IValid", 64'(IValid), 64'(ev_i));
    chk("DValid", 64'(DValid), 64'(ev_d));
    if (ev_i) chk("IRData", 64'(IRData), 64'(resp_data));
    if (ev_d) chk("DRData", 64'(DRData), 64'(resp_data));
    last_ig = eg_i;
    last_dg = eg_d;
    if (!nReset) begin
      cur = '{re: 1'b0, we: 1'b0, addr: 16'h0, wdata: 32'h0, tag: 0, data: 32'h0};
      resp_tag = 0; m_cnt = 0; m_locked = 1'b0;
    end else begin
      resp_tag  = cur.tag;
      resp_data = cur.data;
      cur.re = 1'b0; cur.we = 1'b0; cur.tag = 0;
      if (eg_i) begin
        cur.re = 1'b1; cur.addr = IAddr; cur.tag = 1; cur.data = ref_mem[IAddr[7:0]];
      end else if (eg_d) begin
        cur.addr = DAddr; cur.wdata = DWData;
        if (DWrite) begin
          cur.we = 1'b1; ref_mem[DAddr[7:0]] = DWData;
        end else begin
          cur.re = 1'b1; cur.tag = 2; cur.data = ref_mem[DAddr[7:0]];
        end
      end
      if (eg_i || !IReq) m_cnt = 0;
      else if (m_cnt < LIM) m_cnt++;
      if (!m_locked) m_locked = eg_d && DLock;
      else m_locked = DLock;
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); #1; endtask
  task automatic idle();
    IReq = 1'b0; DReq = 1'b0; DWrite = 1'b0; DLock = 1'b0;
  endtask

  initial begin
    string pat;
    nReset = 1'b0; IReq = 1'b1; DReq = 1'b1; DWrite = 1'b0; DLock = 1'b0;
    IAddr = 16'h0; DAddr = 16'h0; DWData = 32'h0;

    // Reset then idle
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("rst_grants", {62'd0, IGnt, DGnt}, 64'd0);
      chk("rst_mem_en", {62'd0, MemReadEn, MemWriteEn}, 64'd0);
      tick();
    end
    nReset = 1'b1;
    mid(); chk("first_grant_d", {62'd0, IGnt, DGnt}, 64'd1);
    tick(); idle(); tick(); tick(); tick();

    // Single fetch
    IReq = 1'b1; IAddr = 16'h0010;
    mid(); chk("fetch_gnt", 64'(IGnt), 64'd1);
    tick(); idle();
    mid(); chk("fetch_cmd", {47'd0, MemReadEn, MemAddr}, {47'd0, 1'b1, 16'h0010});
    tick();
    mid(); chk("fetch_valid", {62'd0, IValid, DValid}, 64'd2);
    chk("fetch_data", 64'(IRData), 64'h0000_0000_DEAD_BEEF);
    tick(); tick();

    // Contention and starvation
    IReq = 1'b1; IAddr = 16'h0044; DReq = 1'b1; DAddr = 16'h0055;
    pat = "";
    for (int i = 0; i < 10; i++) begin
      mid();
      pat = {pat, IGnt ? "I" : (DGnt ? "D" : "-")};
      tick();
    end
    n_chk++;
    if (pat == "DDDDIDDDDI") n_pass++;
    else $display("FAIL starve_pattern: got %s expected DDDDIDDDDI", pat);
    idle(); tick(); tick(); tick();

    // Lock
    IReq = 1'b1; IAddr = 16'h0040; DReq = 1'b1; DLock = 1'b1; DAddr = 16'h0030;
    mid(); chk("lock_gnt", {61'd0, DGnt, IGnt, Busy}, 64'd4);
    tick();
    for (int i = 0; i < 6; i++) begin
      DReq = (i == 2); DWrite = (i == 2); DAddr = 16'h0020; DWData = 32'h0000_0005;
      mid(); chk("locked", {62'd0, Busy, IGnt}, 64'd2);
      tick();
    end
    DLock = 1'b0; DReq = 1'b0; DWrite = 1'b0;
    mid(); chk("release_cycle", {62'd0, Busy, IGnt}, 64'd2);
    tick();
    mid(); chk("after_release", {62'd0, Busy, IGnt}, 64'd1);
    tick(); idle();
    DReq = 1'b1; DAddr = 16'h0020;
    tick(); idle(); tick();
    mid(); chk("locked_write_data", {31'd0, DValid, DRData}, {31'd0, 1'b1, 32'h0000_0005});
    tick(); tick();

    // Pipelined mix
    for (int r = 0; r < 2; r++) begin
      DReq = 1'b1; DWrite = 1'b1; DAddr = 16'h0004; DWData = 32'h1234_5678 + 32'(r);
      tick();
      DWrite = 1'b0;
      tick();
      DReq = 1'b0; IReq = 1'b1; IAddr = 16'h0008;
      mid(); chk("mix_no_wr_valid", {62'd0, IValid, DValid}, 64'd0);
      tick(); idle();
      mid(); chk("mix_dread", {31'd0, DValid, DRData}, {31'd0, 1'b1, 32'h1234_5678 + 32'(r)});
      tick();
      mid(); chk("mix_iread", {31'd0, IValid, IRData}, {31'd0, 1'b1, init_word(8)});
      tick();
    end

    // Reset mid-read
    DReq = 1'b1; DAddr = 16'h0010;
    mid(); chk("rmr_gnt", 64'(DGnt), 64'd1);
    tick(); idle(); nReset = 1'b0;
    tick(); nReset = 1'b1;
    mid(); chk("rmr_after", {62'd0, DValid, MemReadEn}, 64'd0);
    tick(); tick();

    // Randomized traffic obeying the hold-until-grant rule
    for (int c = 0; c < 3000; c++) begin
      if (!IReq || last_ig) begin
        IReq = $urandom_range(0, 99) < 60; IAddr = {8'h00, 8'($urandom)};
      end else if ($urandom_range(0, 9) == 0) IReq = 1'b0;
      if (!DReq || last_dg) begin
        DReq = $urandom_range(0, 99) < 55; DWrite = $urandom_range(0, 1) == 1;
        DAddr = {8'h00, 8'($urandom_range(0, 15))}; DWData = $urandom;
      end else if ($urandom_range(0, 9) == 0) DReq = 1'b0;
      DLock  = $urandom_range(0, 9) < 3;
      nReset = $urandom_range(0, 199) != 0;
      tick();
    end
    idle(); nReset = 1'b1;
    tick(); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
